// File: rtl/usb_out_ep_buffer.sv
// Bulk OUT endpoint buffer: speculative packet store with commit/rollback,
// ACK/NAK/STALL decision, and a registered request/grant byte read port.
module usb_out_ep_buffer #(
    parameter int DEPTH_LOG2 = 7,
    parameter int MAX_PKT    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pkt_start,
    input  logic       rx_setup,
    input  logic       rx_data_put,
    input  logic [7:0] rx_data,
    input  logic       rx_pkt_end,
    input  logic       rx_pkt_valid,
    output logic       rx_hs_valid,
    output logic [1:0] rx_hs,
    input  logic       out_ep_req,
    output logic       out_ep_grant,
    output logic       out_ep_data_avail,
    output logic       out_ep_setup,
    input  logic       out_ep_data_get,
    output logic [7:0] out_ep_data,
    input  logic       out_ep_stall,
    output logic       out_ep_acked
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int CW = $clog2(MAX_PKT + 1);
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] MAX_P   = PW'(MAX_PKT);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_PKT);

    localparam logic [1:0] HS_NONE  = 2'd0;
    localparam logic [1:0] HS_ACK   = 2'd1;
    localparam logic [1:0] HS_NAK   = 2'd2;
    localparam logic [1:0] HS_STALL = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    logic [7:0]    mem [0:(1<<DEPTH_LOG2)-1];

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overrun_q, overrun_d;
    logic          setup_lat_q, setup_lat_d;
    logic [1:0]    saved_hs_q, saved_hs_d;
    logic          stalled_q, stalled_d;
    logic          hs_valid_q, hs_valid_d;
    logic [1:0]    hs_q, hs_d;
    logic          grant_q, grant_d;
    logic          setup_q, setup_d;
    logic          acked_q, acked_d;
    logic [7:0]    data_q, data_d;

    logic          empty;
    logic [PW-1:0] free;
    logic          start_stall;
    logic          start_nak;
    logic          in_recv;
    logic          commit;
    logic          wr_en;
    logic          get_ok;

    assign empty       = (commit_ptr_q == rd_ptr_q);
    assign free        = DEPTH_P - (commit_ptr_q - rd_ptr_q);
    assign start_stall = stalled_q && !rx_setup;
    assign start_nak   = !start_stall && (free < MAX_P);
    assign in_recv     = (state_q == S_RECV) && !rx_pkt_start;
    assign commit      = in_recv && rx_pkt_end && rx_pkt_valid && !overrun_q;
    assign wr_en       = in_recv && !rx_pkt_end && rx_data_put && (cnt_q != MAX_C);
    assign get_ok      = out_ep_data_get && grant_q && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            overrun_q    <= 1'b0;
            setup_lat_q  <= 1'b0;
            saved_hs_q   <= HS_NONE;
            stalled_q    <= 1'b0;
            hs_valid_q   <= 1'b0;
            hs_q         <= HS_NONE;
            grant_q      <= 1'b0;
            setup_q      <= 1'b0;
            acked_q      <= 1'b0;
            data_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            overrun_q    <= overrun_d;
            setup_lat_q  <= setup_lat_d;
            saved_hs_q   <= saved_hs_d;
            stalled_q    <= stalled_d;
            hs_valid_q   <= hs_valid_d;
            hs_q         <= hs_d;
            grant_q      <= grant_d;
            setup_q      <= setup_d;
            acked_q      <= acked_d;
            data_q       <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    // A new start always wins: it abandons whatever packet was in flight.
    always_comb begin
        state_d = state_q;
        if (rx_pkt_start) begin
            state_d = (start_stall || start_nak) ? S_DROP : S_RECV;
        end else if (state_q != S_IDLE && rx_pkt_end) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        overrun_d    = overrun_q;
        setup_lat_d  = setup_lat_q;
        saved_hs_d   = saved_hs_q;
        stalled_d    = stalled_q;
        hs_valid_d   = 1'b0;
        hs_d         = HS_NONE;
        grant_d      = out_ep_req;
        setup_d      = setup_q;
        acked_d      = 1'b0;

        if (get_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (rx_pkt_start) begin
            wr_ptr_d    = commit_ptr_q;
            cnt_d       = '0;
            overrun_d   = 1'b0;
            setup_lat_d = rx_setup;
            saved_hs_d  = start_stall ? HS_STALL : HS_NAK;
        end else if (state_q == S_RECV) begin
            if (rx_pkt_end) begin
                if (commit) begin
                    commit_ptr_d = wr_ptr_q;
                    acked_d      = 1'b1;
                    setup_d      = setup_lat_q;
                    hs_valid_d   = 1'b1;
                    hs_d         = HS_ACK;
                    // SETUP flushes stale OUT data so only its payload remains.
                    if (setup_lat_q) begin
                        rd_ptr_d  = commit_ptr_q;
                        stalled_d = 1'b0;
                    end
                end else begin
                    wr_ptr_d = commit_ptr_q;
                end
            end else if (rx_data_put) begin
                if (cnt_q == MAX_C) begin
                    overrun_d = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
        end else if (state_q == S_DROP && rx_pkt_end) begin
            hs_valid_d = 1'b1;
            hs_d       = saved_hs_q;
        end

        if (out_ep_stall) begin
            stalled_d = 1'b1;
        end

        data_d = mem[rd_ptr_d[DEPTH_LOG2-1:0]];
    end

    assign rx_hs_valid       = hs_valid_q;
    assign rx_hs             = hs_q;
    assign out_ep_grant      = grant_q;
    assign out_ep_data_avail = !empty;
    assign out_ep_setup      = setup_q;
    assign out_ep_data       = data_q;
    assign out_ep_acked      = acked_q;

endmodule

// File: tb/tb_usb_out_ep_buffer.sv
// Scoreboard bench for usb_out_ep_buffer: stimulus pushes expected handshakes,
// commits and bytes; a negedge monitor pops and compares as the DUT presents them.
module tb_usb_out_ep_buffer;
    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] ACK   = 2'd1;
    localparam logic [1:0] NAK   = 2'd2;
    localparam logic [1:0] STALL = 2'd3;
    localparam int BIG = 32'h7fff_ffff;

    logic       clk;
    logic       reset;
    logic       rx_pkt_start, rx_setup, rx_data_put, rx_pkt_end, rx_pkt_valid;
    logic [7:0] rx_data;
    logic       rx_hs_valid;
    logic [1:0] rx_hs;
    logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
    logic       out_ep_data_get, out_ep_stall, out_ep_acked;
    logic [7:0] out_ep_data;

    logic       reader_get, man_get;
    int         errors, checks, cyc, reader_cnt, reader_limit;
    bit         prev_avail;
    logic [7:0] data_exp [$];
    logic [1:0] hs_exp [$];
    int         hs_cyc [$];
    bit         ack_exp [$];
    int         ack_cyc [$];
    logic [7:0] pkt [0:127];

    assign out_ep_data_get = reader_get | man_get;

    usb_out_ep_buffer #(.DEPTH_LOG2(7), .MAX_PKT(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_pkt_start     (rx_pkt_start),
        .rx_setup         (rx_setup),
        .rx_data_put      (rx_data_put),
        .rx_data          (rx_data),
        .rx_pkt_end       (rx_pkt_end),
        .rx_pkt_valid     (rx_pkt_valid),
        .rx_hs_valid      (rx_hs_valid),
        .rx_hs            (rx_hs),
        .out_ep_req       (out_ep_req),
        .out_ep_grant     (out_ep_grant),
        .out_ep_data_avail(out_ep_data_avail),
        .out_ep_setup     (out_ep_setup),
        .out_ep_data_get  (out_ep_data_get),
        .out_ep_data      (out_ep_data),
        .out_ep_stall     (out_ep_stall),
        .out_ep_acked     (out_ep_acked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit setup, input int n, input bit good,
                        input logic [1:0] hs, input bit commit);
        if (commit) begin
            if (setup) data_exp.delete();
            for (int i = 0; i < n; i++) data_exp.push_back(pkt[i]);
        end
        rx_pkt_start = 1'b1;
        rx_setup     = setup;
        tick();
        rx_pkt_start = 1'b0;
        rx_setup     = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_data_put = 1'b1;
            rx_data     = pkt[i];
            tick();
        end
        rx_data_put  = 1'b0;
        rx_pkt_end   = 1'b1;
        rx_pkt_valid = good;
        if (hs != NONE) begin
            hs_exp.push_back(hs);
            hs_cyc.push_back(cyc + 1);
        end
        if (commit) begin
            ack_exp.push_back(setup);
            ack_cyc.push_back(cyc + 1);
        end
        tick();
        rx_pkt_end   = 1'b0;
        rx_pkt_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while (data_exp.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check(name, data_exp.size(), 0);
        tick();
        check({name, "_avail"}, out_ep_data_avail, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        rx_pkt_start = 0; rx_setup = 0; rx_data_put = 0; rx_data = 0;
        rx_pkt_end = 0; rx_pkt_valid = 0; out_ep_req = 0; out_ep_stall = 0;
        reader_get = 0; man_get = 0;
        errors = 0; checks = 0; cyc = 0; reader_cnt = 0; reader_limit = 0;
        prev_avail = 0;
        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin : reader
                @(posedge clk);
                #1;
                reader_get = out_ep_grant && out_ep_data_avail && prev_avail &&
                             (reader_cnt < reader_limit);
                if (reader_get) reader_cnt++;
                prev_avail = out_ep_data_avail;
            end
            forever begin : monitor
                logic [7:0] e;
                logic [1:0] h;
                int         c;
                bit         s;
                @(negedge clk);
                if (!reset) begin
                    if (out_ep_data_get && out_ep_grant && out_ep_data_avail) begin
                        if (data_exp.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL rd_unexpected: got %02h expected no byte", out_ep_data);
                        end else begin
                            e = data_exp.pop_front();
                            check("rd_data", out_ep_data, e);
                        end
                    end
                    if (rx_hs_valid) begin
                        if (hs_exp.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL hs_unexpected: got %0d expected no handshake", rx_hs);
                        end else begin
                            h = hs_exp.pop_front();
                            c = hs_cyc.pop_front();
                            check("hs_code", rx_hs, h);
                            check("hs_cycle", cyc, c);
                        end
                    end
                    if (out_ep_acked) begin
                        if (ack_exp.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL ack_unexpected: got 1 expected 0");
                        end else begin
                            s = ack_exp.pop_front();
                            c = ack_cyc.pop_front();
                            check("ack_setup", out_ep_setup, s);
                            check("ack_cycle", cyc, c);
                            check("avail_at_ack", out_ep_data_avail, 1'b1);
                        end
                    end
                end
            end
            begin : main
                repeat (3) tick();
                @(negedge clk);
                check("rst_hs_valid", rx_hs_valid, 1'b0);
                check("rst_hs", rx_hs, 2'd0);
                check("rst_grant", out_ep_grant, 1'b0);
                check("rst_setup", out_ep_setup, 1'b0);
                check("rst_acked", out_ep_acked, 1'b0);
                check("rst_data", out_ep_data, 8'h00);
                check("rst_avail", out_ep_data_avail, 1'b0);
                tick();
                reset = 1'b0;
                out_ep_req = 1'b1;
                reader_limit = BIG;
                tick(); tick();
                check("grant_follows_req", out_ep_grant, 1'b1);

                // good 5-byte packet
                pkt[0] = 8'h01; pkt[1] = 8'h10; pkt[2] = 8'h00; pkt[3] = 8'h04; pkt[4] = 8'h00;
                send(0, 5, 1, ACK, 1);
                wait_drain("drain_5", 50);

                // bad CRC packet rolled back, then good 2-byte packet
                pkt[0] = 8'h33; pkt[1] = 8'h44; pkt[2] = 8'h55;
                send(0, 3, 0, NONE, 0);
                check("avail_after_bad", out_ep_data_avail, 1'b0);
                pkt[0] = 8'hAA; pkt[1] = 8'hBB;
                send(0, 2, 1, ACK, 1);
                wait_drain("drain_aabb", 50);

                // fill to full, NAK, partial read, refill across pointer wrap
                reader_limit = reader_cnt;
                for (int i = 0; i < 64; i++) pkt[i] = 8'(i);
                send(0, 64, 1, ACK, 1);
                for (int i = 0; i < 64; i++) pkt[i] = 8'(i) | 8'h80;
                send(0, 64, 1, ACK, 1);
                for (int i = 0; i < 64; i++) pkt[i] = 8'(i) ^ 8'h55;
                send(0, 64, 1, NAK, 0);
                check("full_exp_bytes", data_exp.size(), 128);
                reader_limit = reader_cnt + 64;
                for (int n = 0; n < 200 && data_exp.size() > 64; n++) tick();
                repeat (4) tick();
                check("read64_left", data_exp.size(), 64);
                for (int i = 0; i < 64; i++) pkt[i] = 8'(3 * i + 7);
                send(0, 64, 1, ACK, 1);
                reader_limit = BIG;
                wait_drain("drain_wrap", 300);

                // 65-byte packet overruns and is dropped silently
                for (int i = 0; i < 65; i++) pkt[i] = 8'(i) ^ 8'hA5;
                send(0, 65, 1, NONE, 0);
                check("avail_after_overrun", out_ep_data_avail, 1'b0);

                // stall, STALL handshake, SETUP clears stall and flushes unread data
                reader_limit = reader_cnt;
                pkt[0] = 8'hD0; pkt[1] = 8'hD1; pkt[2] = 8'hD2; pkt[3] = 8'hD3;
                send(0, 4, 1, ACK, 1);
                out_ep_stall = 1'b1;
                tick();
                out_ep_stall = 1'b0;
                tick();
                send(0, 4, 1, STALL, 0);
                for (int i = 0; i < 8; i++) pkt[i] = 8'h20 + 8'(i);
                send(1, 8, 1, ACK, 1);
                check("setup_flag", out_ep_setup, 1'b1);
                pkt[0] = 8'h71; pkt[1] = 8'h72; pkt[2] = 8'h73;
                send(0, 3, 1, ACK, 1);
                check("setup_flag_after_out", out_ep_setup, 1'b0);
                reader_limit = BIG;
                wait_drain("drain_setup", 60);

                // gets ignored while grant is low
                reader_limit = reader_cnt;
                pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
                send(0, 3, 1, ACK, 1);
                out_ep_req = 1'b0;
                tick(); tick();
                man_get = 1'b1;
                repeat (3) tick();
                man_get = 1'b0;
                check("nogrant_grant", out_ep_grant, 1'b0);
                check("nogrant_avail", out_ep_data_avail, 1'b1);
                check("nogrant_head", out_ep_data, 8'h11);
                out_ep_req = 1'b1;
                tick(); tick();
                reader_limit = BIG;
                wait_drain("drain_nogrant", 40);

                // gets ignored on an empty buffer
                man_get = 1'b1;
                repeat (3) tick();
                man_get = 1'b0;
                check("empty_get_avail", out_ep_data_avail, 1'b0);

                // commit lands while the reader is streaming the previous packet
                for (int i = 0; i < 40; i++) pkt[i] = 8'(i) + 8'h60;
                send(0, 40, 1, ACK, 1);
                pkt[0] = 8'hF1; pkt[1] = 8'hF2; pkt[2] = 8'hF3;
                send(0, 3, 1, ACK, 1);
                wait_drain("drain_concurrent", 200);

                // reset mid-packet: nothing stored, no handshake
                rx_pkt_start = 1'b1;
                tick();
                rx_pkt_start = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    rx_data_put = 1'b1;
                    rx_data     = 8'hE0 + 8'(i);
                    tick();
                end
                rx_data_put = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                tick();
                rx_pkt_end = 1'b1;
                rx_pkt_valid = 1'b1;
                tick();
                rx_pkt_end = 1'b0;
                rx_pkt_valid = 1'b0;
                repeat (3) tick();
                check("avail_after_reset", out_ep_data_avail, 1'b0);

                check("hs_queue_empty", hs_exp.size(), 0);
                check("ack_queue_empty", ack_exp.size(), 0);
                check("data_queue_empty", data_exp.size(), 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join
    end

endmodule
